// File: rtl/md_unit.sv
// md_unit: multiply/divide unit and HI/LO sequencer for the E stage.
// A mult/div result is computed in one shot on the start edge, parked in
// res_hi/res_lo, and committed to HI/LO only when the busy countdown ends,
// so the timing looks like a real iterative unit to the rest of the pipeline.
// Optional build macro: MD_DIV0_KEEP_EN -- when defined, a divide by zero
// leaves HI/LO untouched; when undefined it commits hi=a, lo=32'hFFFF_FFFF.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  e_class,
  input  logic        e_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  d_class,
  output logic        start,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [3:0] CLS_MULT  = 4'd1;
  localparam logic [3:0] CLS_MULTU = 4'd2;
  localparam logic [3:0] CLS_DIV   = 4'd3;
  localparam logic [3:0] CLS_DIVU  = 4'd4;
  localparam logic [3:0] CLS_MFHI  = 4'd5;
  localparam logic [3:0] CLS_MFLO  = 4'd6;
  localparam logic [3:0] CLS_MTHI  = 4'd7;
  localparam logic [3:0] CLS_MTLO  = 4'd8;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [31:0]        res_hi;
  logic [31:0]        res_lo;
  logic               res_commit;

  logic               is_mult;
  logic               is_div;
  logic               mt_hi;
  logic               mt_lo;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        calc_hi;
  logic [31:0]        calc_lo;
  logic               calc_commit;

  assign is_mult = (e_class == CLS_MULT) || (e_class == CLS_MULTU);
  assign is_div  = (e_class == CLS_DIV)  || (e_class == CLS_DIVU);

  // Pipeline-facing decode: launches, HI/LO moves and the D-stage stall
  always_comb begin
    start    = e_valid && (is_mult || is_div) && (state_q == IDLE);
    mt_hi    = e_valid && (e_class == CLS_MTHI) && (state_q == IDLE);
    mt_lo    = e_valid && (e_class == CLS_MTLO) && (state_q == IDLE);
    md_stall = (start || busy) && (d_class != 4'd0);
    md_out   = 32'd0;
    if (e_class == CLS_MFHI) begin
      md_out = hi;
    end else if (e_class == CLS_MFLO) begin
      md_out = lo;
    end
  end

  // Full-width products; sign-extending first makes the low 64 bits exact
  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Result that will be parked on the start edge; divide-by-zero and the
  // most-negative / -1 overflow are forced to deterministic values
  always_comb begin
    calc_hi     = 32'd0;
    calc_lo     = 32'd0;
    calc_commit = 1'b1;
    quot_s      = 32'sd0;
    rem_s       = 32'sd0;
    case (e_class)
      CLS_MULT: begin
        calc_hi = prod_s[63:32];
        calc_lo = prod_s[31:0];
      end
      CLS_MULTU: begin
        calc_hi = prod_u[63:32];
        calc_lo = prod_u[31:0];
      end
      CLS_DIV, CLS_DIVU: begin
        if (b == 32'd0) begin
`ifdef MD_DIV0_KEEP_EN
          calc_commit = 1'b0;
`else
          calc_hi = a;
          calc_lo = 32'hFFFF_FFFF;
`endif
        end else if (e_class == CLS_DIVU) begin
          calc_lo = a / b;
          calc_hi = a % b;
        end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
          calc_lo = a;
          calc_hi = 32'd0;
        end else begin
          quot_s  = $signed(a) / $signed(b);
          rem_s   = $signed(a) % $signed(b);
          calc_lo = quot_s;
          calc_hi = rem_s;
        end
      end
      default: begin
        calc_commit = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a launch enters RUN, the last countdown cycle returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (cnt_q == CNT_W'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: park result on launch, count down, commit on the final cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      busy       <= 1'b0;
      cnt_q      <= '0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      res_hi     <= 32'd0;
      res_lo     <= 32'd0;
      res_commit <= 1'b0;
    end else begin
      if (start) begin
        res_hi     <= calc_hi;
        res_lo     <= calc_lo;
        res_commit <= calc_commit;
        cnt_q      <= is_mult ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        busy       <= 1'b1;
      end else if (state_q == RUN) begin
        cnt_q <= cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          busy <= 1'b0;
          if (res_commit) begin
            hi <= res_hi;
            lo <= res_lo;
          end
        end
      end
      if (mt_hi) hi <= a;
      if (mt_lo) lo <= a;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: table of directed md operations plus hand-written corner
// sequences and a random run, all checked against a cycle-level model that
// tracks HI/LO and the number of busy cycles remaining.
module tb_md_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  e_class;
  logic        e_valid;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  d_class;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] md_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pcommit;
  int          m_rem;
  bit          last_stall;

  typedef struct {
    string       name;
    logic [3:0]  cls;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
    int          cycles;
  } vec_t;

  vec_t tv[11];

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .e_class(e_class), .e_valid(e_valid),
    .a(a), .b(b), .d_class(d_class), .start(start), .busy(busy),
    .md_stall(md_stall), .hi(hi), .lo(lo), .md_out(md_out)
  );

  always #5 clk = ~clk;

  // Reference for one operation, straight from the arithmetic definitions
  function automatic void ref_op(input logic [3:0] c, input logic [31:0] x, y,
                                 output logic [31:0] rh, rl, output bit commit);
    longint          sp;
    longint unsigned up;
    int              sx, sy;
    sx = x;
    sy = y;
    rh = 32'd0;
    rl = 32'd0;
    commit = 1'b1;
    if (c == 4'd1) begin
      sp = longint'(sx) * longint'(sy);
      rh = sp[63:32];
      rl = sp[31:0];
    end else if (c == 4'd2) begin
      up = 64'(x) * 64'(y);
      rh = up[63:32];
      rl = up[31:0];
    end else if (y == 32'd0) begin
`ifdef MD_DIV0_KEEP_EN
      commit = 1'b0;
`else
      rh = x;
      rl = 32'hFFFF_FFFF;
`endif
    end else if (c == 4'd3) begin
      rl = sx / sy;
      rh = sx % sy;
    end else begin
      rl = x / y;
      rh = x % y;
    end
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One E-stage cycle: drive, check combinational and registered outputs
  // against the model, then advance the model across the clock edge
  task automatic applyStimulus(input logic [3:0] ec, input bit ev,
                               input logic [31:0] aa, bb, input logic [3:0] dc);
    bit          exp_start;
    logic [31:0] exp_out;
    e_class = ec;
    e_valid = ev;
    a       = aa;
    b       = bb;
    d_class = dc;
    #1;
    exp_start = ev && (ec >= 4'd1) && (ec <= 4'd4) && (m_rem == 0);
    exp_out   = (ec == 4'd5) ? m_hi : (ec == 4'd6) ? m_lo : 32'd0;
    checkOutput("start", 32'(start), 32'(exp_start));
    checkOutput("busy", 32'(busy), 32'(m_rem > 0));
    checkOutput("md_stall", 32'(md_stall), 32'((exp_start || m_rem > 0) && dc != 4'd0));
    checkOutput("md_out", md_out, exp_out);
    checkOutput("hi", hi, m_hi);
    checkOutput("lo", lo, m_lo);
    last_stall = md_stall;
    @(posedge clk);
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_pcommit) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (exp_start) begin
      ref_op(ec, aa, bb, m_phi, m_plo, m_pcommit);
      m_rem = (ec <= 4'd2) ? MULT_N : DIV_N;
    end else if (ev && ec == 4'd7) begin
      m_hi = aa;
    end else if (ev && ec == 4'd8) begin
      m_lo = aa;
    end
    #1;
  endtask

  task automatic doReset();
    reset   = 1'b1;
    e_class = 4'd0;
    e_valid = 1'b0;
    a       = 32'd0;
    b       = 32'd0;
    d_class = 4'd0;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    m_hi      = 32'd0;
    m_lo      = 32'd0;
    m_phi     = 32'd0;
    m_plo     = 32'd0;
    m_pcommit = 1'b0;
    m_rem     = 0;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 30) begin
      applyStimulus(4'd0, 1'b1, 32'd0, 32'd0, 4'd0);
      n++;
    end
  endtask

  initial begin
    int          n;
    int          stall_cnt;
    logic [3:0]  rc, rd;
    logic [31:0] ra, rb;
    bit          rv;

    tv[0]  = '{"mult",      4'd1, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, MULT_N};
    tv[1]  = '{"multu",     4'd2, 32'hFFFF_FFFF, 32'd2,         32'h0000_0001, 32'hFFFF_FFFE, MULT_N};
    tv[2]  = '{"div",       4'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_N};
    tv[3]  = '{"divu",      4'd4, 32'd7,         32'd2,         32'd1,         32'd3,         DIV_N};
    tv[4]  = '{"mthi",      4'd7, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'd3,         0};
    tv[5]  = '{"mtlo",      4'd8, 32'h0000_5678, 32'd0,         32'h0000_1234, 32'h0000_5678, 0};
`ifdef MD_DIV0_KEEP_EN
    tv[6]  = '{"divu_by0",  4'd4, 32'd9,         32'd0,         32'h0000_1234, 32'h0000_5678, DIV_N};
    tv[7]  = '{"div_by0",   4'd3, 32'hFFFF_FFFB, 32'd0,         32'h0000_1234, 32'h0000_5678, DIV_N};
`else
    tv[6]  = '{"divu_by0",  4'd4, 32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF, DIV_N};
    tv[7]  = '{"div_by0",   4'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_N};
`endif
    tv[8]  = '{"div_pos_n", 4'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, DIV_N};
    tv[9]  = '{"div_n_n",   4'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         DIV_N};
    tv[10] = '{"multu_big", 4'd2, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0,         MULT_N};

    doReset();
    doReset();
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_hi", hi, 32'd0);
    checkOutput("rst_lo", lo, 32'd0);
    checkOutput("rst_start", 32'(start), 32'd0);

    // Directed operation table
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tv[i].cls, 1'b1, tv[i].a, tv[i].b, 4'd0);
      waitIdle(n);
      checkOutput({tv[i].name, "_cycles"}, 32'(n), 32'(tv[i].cycles));
      checkOutput({tv[i].name, "_hi"}, hi, tv[i].exp_hi);
      checkOutput({tv[i].name, "_lo"}, lo, tv[i].exp_lo);
    end

    // mflo waiting in D behind a mult: stall for start cycle plus busy cycles
    stall_cnt = 0;
    applyStimulus(4'd1, 1'b1, 32'hFFFF_FFFD, 32'd7, 4'd6);
    stall_cnt += int'(last_stall);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(4'd0, 1'b1, 32'd0, 32'd0, 4'd6);
      stall_cnt += int'(last_stall);
    end
    checkOutput("mflo_stall_cycles", 32'(stall_cnt), 32'd6);
    applyStimulus(4'd6, 1'b1, 32'd0, 32'd0, 4'd0);
    checkOutput("mflo_value", md_out, 32'hFFFF_FFEB);

    // D-stage add (class 0) never stalls; launch while busy is ignored
    applyStimulus(4'd1, 1'b1, 32'd2, 32'd3, 4'd0);
    checkOutput("add_no_stall", 32'(last_stall), 32'd0);
    applyStimulus(4'd3, 1'b1, 32'd100, 32'd7, 4'd0);
    waitIdle(n);
    checkOutput("ignore_cycles", 32'(n), 32'(MULT_N - 1));
    checkOutput("ignore_hi", hi, 32'd0);
    checkOutput("ignore_lo", lo, 32'd6);

    // e_valid=0 suppresses launch and HI/LO moves
    applyStimulus(4'd1, 1'b0, 32'd5, 32'd5, 4'd0);
    applyStimulus(4'd7, 1'b0, 32'hDEAD_BEEF, 32'd0, 4'd0);
    checkOutput("nv_busy", 32'(busy), 32'd0);
    checkOutput("nv_hi", hi, 32'd0);

    // Reset on the third busy cycle of a divide aborts with no commit
    applyStimulus(4'd4, 1'b1, 32'd50, 32'd7, 4'd0);
    applyStimulus(4'd0, 1'b1, 32'd0, 32'd0, 4'd0);
    applyStimulus(4'd0, 1'b1, 32'd0, 32'd0, 4'd0);
    doReset();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_hi", hi, 32'd0);
    checkOutput("abort_lo", lo, 32'd0);
    for (int k = 0; k < 12; k++) applyStimulus(4'd0, 1'b1, 32'd0, 32'd0, 4'd0);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      rc = 4'($urandom_range(0, 8));
      rv = ($urandom_range(0, 3) != 0);
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd1;
      rd = 4'($urandom_range(0, 8));
      applyStimulus(rc, rv, ra, rb, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
